// File: rtl/spi_packet_rx_if.sv
// Parallel word stream from the SPI packet receiver to the per-channel buffers.
// word_valid is a one-cycle strobe qualifying word_data/word_ch; word_ready only reports consumer capacity and never stalls the producer.
interface spi_packet_rx_if #(
    parameter int WORD_W = 8,
    parameter int CH_W   = 2
);
    logic [WORD_W-1:0] word_data;
    logic [CH_W-1:0]   word_ch;
    logic              word_valid;
    logic              word_ready;

    modport master (output word_data, word_ch, word_valid, input word_ready);
    modport slave  (input word_data, word_ch, word_valid, output word_ready);
endinterface

// File: rtl/spi_packet_rx.sv
// SPI packet receiver: hunts a tolerant header on MISO, decodes channel and length,
// and emits the payload as channel-tagged parallel words, several packets per request.
module spi_packet_rx #(
    parameter int              HDR_W        = 8,
    parameter logic [HDR_W-1:0] HDR_PATTERN = 8'hA5,
    parameter int              MATCH_MIN    = 8,
    parameter int              CH_W         = 2,
    parameter int              NUM_CH       = 3,
    parameter int              LEN_W        = 12,
    parameter int              WORD_W       = 8,
    parameter int              PKTS_PER_REQ = 2,
    parameter int              SETUP_BITS   = 16,
    parameter int              HUNT_TIMEOUT = 4096
) (
    input  logic                   CLK_40,
    input  logic                   rst,
    input  logic                   spi_clk_rise,
    input  logic                   spi_clk_fall,
    input  logic                   MISO,
    input  logic                   start_req,
    spi_packet_rx_if.master        word_if,
    output logic                   chip_select,
    output logic                   pkt_done,
    output logic                   pkt_err,
    output logic                   overflow,
    output logic                   busy,
    output logic [3:0]             state_dbg
);

    localparam int SH_W    = (LEN_W > WORD_W) ? ((LEN_W > CH_W) ? LEN_W : CH_W)
                                              : ((WORD_W > CH_W) ? WORD_W : CH_W);
    localparam int CNT_MAX = (SETUP_BITS > SH_W) ? SETUP_BITS : SH_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int HC_W    = $clog2(HUNT_TIMEOUT + 1);
    localparam int PC_W    = $clog2(PKTS_PER_REQ + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_BITS - 1);
    localparam logic [CNT_W-1:0] CH_LAST    = CNT_W'(CH_W - 1);
    localparam logic [CNT_W-1:0] LEN_LAST   = CNT_W'(LEN_W - 1);
    localparam logic [CNT_W-1:0] WORD_LAST  = CNT_W'(WORD_W - 1);
    localparam logic [HC_W-1:0]  HUNT_MIN   = HC_W'(HDR_W);
    localparam logic [HC_W-1:0]  HUNT_MAX   = HC_W'(HUNT_TIMEOUT);
    localparam logic [CH_W:0]    NUM_CH_C   = (CH_W + 1)'(NUM_CH);
    localparam logic [PC_W-1:0]  PKTS_C     = PC_W'(PKTS_PER_REQ);

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_HUNT, S_CHAN, S_LEN, S_PAYLOAD, S_PEND, S_DONE, S_ERR
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]  bit_cnt;
    logic [HC_W-1:0]   hunt_cnt, hunt_next;
    logic [HDR_W-2:0]  hdr_sh;
    logic [HDR_W-1:0]  hdr_next;
    logic [SH_W-2:0]   fld_sh;
    logic [SH_W-1:0]   fld_next;
    logic [LEN_W-1:0]  len;
    logic [PC_W-1:0]   pkt_cnt;
    logic [WORD_W-1:0] word_data_q;
    logic [CH_W-1:0]   word_ch_q;
    logic              word_valid_q;
    logic              hdr_match, bit_last, fall_only, counting;

    function automatic int ones(input logic [HDR_W-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < HDR_W; i++) n += int'(v[i]);
        return n;
    endfunction

    always_ff @(posedge CLK_40 or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        fall_only  = spi_clk_fall & ~spi_clk_rise;
        hdr_next   = {hdr_sh, MISO};
        fld_next   = {fld_sh, MISO};
        hunt_next  = hunt_cnt + 1'b1;
        hdr_match  = (hunt_next >= HUNT_MIN) && (ones(~(hdr_next ^ HDR_PATTERN)) >= MATCH_MIN);
        bit_last   = 1'b0;
        counting   = 1'b0;
        case (state)
            S_SETUP:   begin bit_last = (bit_cnt == SETUP_LAST); counting = ~chip_select; end
            S_CHAN:    begin bit_last = (bit_cnt == CH_LAST);    counting = 1'b1; end
            S_LEN:     begin bit_last = (bit_cnt == LEN_LAST);   counting = 1'b1; end
            S_PAYLOAD: begin bit_last = (bit_cnt == WORD_LAST);  counting = 1'b1; end
            default:   ;
        endcase
        case (state)
            S_IDLE:    if (start_req) state_next = S_SETUP;
            S_SETUP:   if (spi_clk_rise && counting && bit_last) state_next = S_HUNT;
            S_HUNT:
                if (spi_clk_rise) begin
                    if (hdr_match)                  state_next = S_CHAN;
                    else if (hunt_next == HUNT_MAX) state_next = S_ERR;
                end
            S_CHAN:
                if (spi_clk_rise && bit_last)
                    state_next = ({1'b0, fld_next[CH_W-1:0]} >= NUM_CH_C) ? S_ERR : S_LEN;
            S_LEN:
                if (spi_clk_rise && bit_last)
                    state_next = (fld_next[LEN_W-1:0] == '0) ? S_PEND : S_PAYLOAD;
            S_PAYLOAD:
                if (spi_clk_rise && bit_last && len == LEN_W'(1)) state_next = S_PEND;
            S_PEND:    state_next = (pkt_cnt == PC_W'(1)) ? S_DONE : S_HUNT;
            S_DONE,
            S_ERR:     if (fall_only) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_40 or posedge rst) begin
        if (rst) begin
            bit_cnt      <= '0;
            hunt_cnt     <= '0;
            hdr_sh       <= '0;
            fld_sh       <= '0;
            len          <= '0;
            pkt_cnt      <= '0;
            word_data_q  <= '0;
            word_ch_q    <= '0;
            word_valid_q <= 1'b0;
            pkt_done     <= 1'b0;
            pkt_err      <= 1'b0;
            overflow     <= 1'b0;
            chip_select  <= 1'b1;
        end else begin
            word_valid_q <= 1'b0;
            pkt_done     <= (state == S_PEND);
            pkt_err      <= (state != S_ERR) && (state_next == S_ERR);

            // The field counter restarts on every state change and on every completed payload word.
            if (state_next != state)               bit_cnt <= '0;
            else if (spi_clk_rise && counting)     bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;

            if (state != S_HUNT) begin
                hdr_sh   <= '0;
                hunt_cnt <= '0;
            end else if (spi_clk_rise) begin
                hdr_sh   <= hdr_next[HDR_W-2:0];
                hunt_cnt <= hunt_next;
            end

            if (spi_clk_rise && (state == S_CHAN || state == S_LEN || state == S_PAYLOAD))
                fld_sh <= fld_next[SH_W-2:0];

            if (state == S_CHAN && spi_clk_rise && bit_last && state_next == S_LEN)
                word_ch_q <= fld_next[CH_W-1:0];
            if (state == S_LEN && spi_clk_rise && bit_last)
                len <= fld_next[LEN_W-1:0];
            if (state == S_PAYLOAD && spi_clk_rise && bit_last) begin
                word_valid_q <= 1'b1;
                word_data_q  <= fld_next[WORD_W-1:0];
                len          <= len - 1'b1;
            end

            if (state == S_IDLE && start_req)  pkt_cnt <= PKTS_C;
            else if (state == S_PEND)          pkt_cnt <= pkt_cnt - 1'b1;

            if (state == S_IDLE && start_req)                overflow <= 1'b0;
            else if (word_valid_q && !word_if.word_ready)    overflow <= 1'b1;

            if (state == S_SETUP && fall_only)                           chip_select <= 1'b0;
            else if ((state == S_DONE || state == S_ERR) && fall_only)   chip_select <= 1'b1;
        end
    end

    assign word_if.word_data  = word_data_q;
    assign word_if.word_ch    = word_ch_q;
    assign word_if.word_valid = word_valid_q;
    assign busy               = (state != S_IDLE);
    assign state_dbg          = state;

endmodule

// File: doc/spi_packet_rx.md
# spi_packet_rx

Parametrised SPI packet receiver for the host-to-FPGA data link.
- On a request, asserts chip select and hunts the MISO bit stream for a tolerant header.
- Decodes a channel ID and a length field, then delivers the payload as parallel words tagged with their channel.
- Services a configurable number of packets per request (for example video then audio) before releasing the bus.
- Sits between the SPI pin logic and the per-channel frame/audio buffers, entirely in the CLK_40 domain.

## Interface
Parameters:
- HDR_W, 8: header width in bits.
- HDR_PATTERN, 8'hA5: header value, MSB first on the wire.
- MATCH_MIN, 8: minimum number of matching header bits to accept (1..HDR_W).
- CH_W, 2: channel ID field width.
- NUM_CH, 3: number of valid channels; IDs ≥ NUM_CH are errors.
- LEN_W, 12: length field width, in words.
- WORD_W, 8: payload word width.
- PKTS_PER_REQ, 2: packets received per request.
- SETUP_BITS, 16: SPI rising edges with CS low before hunting starts.
- HUNT_TIMEOUT, 4096: sampled bits allowed in HUNT before abort.

Ports:
- CLK_40  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- spi_clk_rise  in  1  one-cycle strobe at the SPI clock rising edge.
- spi_clk_fall  in  1  one-cycle strobe at the SPI clock falling edge.
- MISO  in  1  serial data, already synchronised.
- start_req  in  1  pulse or level; begins a transaction when IDLE.
- word_ready  in  1  consumer can accept word_data.
- chip_select  out  1  SS, active low.
- word_data  out  WORD_W  payload word, MSB-first assembly.
- word_ch  out  CH_W  channel of word_data.
- word_valid  out  1  one-cycle strobe qualifying word_data/word_ch.
- pkt_done  out  1  one-cycle pulse at the end of each good packet.
- pkt_err  out  1  one-cycle pulse on timeout or bad channel.
- overflow  out  1  sticky; set when word_valid fires while word_ready=0. Cleared by rst or start of a new request.
- busy  out  1  high in every state except IDLE.

## Operation
- All MISO sampling happens only on spi_clk_rise.
- chip_select changes only on spi_clk_fall.
- Reset values: chip_select=1; all other outputs 0; state=IDLE; all counters and shift registers 0.
- States:
  - IDLE: on start_req, clear overflow, load pkt_cnt=PKTS_PER_REQ, go to SETUP.
  - SETUP: drive CS low at the next spi_clk_fall. Count SETUP_BITS rising edges (bits discarded), then go to HUNT.
  - HUNT: shift MISO into an HDR_W shift register (cleared on entry) and count bits since entry.
    - Match when the bit count ≥ HDR_W and popcount(~(shreg ^ HDR_PATTERN)) ≥ MATCH_MIN.
    - Evaluate on the sample that includes the new bit; on match go to CHAN.
    - If the hunt count reaches HUNT_TIMEOUT with no match, go to ERR.
  - CHAN: shift CH_W bits MSB first.
    - ID ≥ NUM_CH: go to ERR.
    - Otherwise latch word_ch and go to LEN.
  - LEN: shift LEN_W bits MSB first into len.
    - len==0: go to PEND.
    - Otherwise go to PAYLOAD.
  - PAYLOAD: assemble WORD_W bits.
    - On each completed word, present word_data/word_ch and pulse word_valid; decrement len.
    - When len reaches 0, go to PEND.
  - PEND: pulse pkt_done and decrement pkt_cnt.
    - If pkt_cnt is now 0, go to DONE.
    - Otherwise go back to HUNT; CS stays low and the header shreg and hunt count are cleared.
  - DONE: raise CS at the next spi_clk_fall, then go to IDLE.
  - ERR: pulse pkt_err and raise CS at the next spi_clk_fall, then go to IDLE. Remaining packets are abandoned.
- start_req is ignored while busy.
- word_ready has no backpressure effect; it only feeds overflow.
- Async rst at any point returns to the reset values immediately, with CS=1; a partial word is discarded.

## Timing
- word_valid is registered: it rises on the CLK_40 edge after the spi_clk_rise cycle that sampled the word's last bit, and stays high for exactly 1 cycle.
- pkt_done and pkt_err each last 1 cycle.
  - pkt_done follows the last word's word_valid by 1 cycle.
  - For len==0, pkt_done follows the last LEN bit's sample by 1 cycle.
- CS-low-to-first-header-bit latency is SETUP_BITS SPI periods.
- The header can be accepted on the HDR_W-th bit after entering HUNT at the earliest.
- Simultaneous spi_clk_rise and spi_clk_fall is illegal (the strobe generator guarantees this). An implementation may ignore the fall.
- Word_data holds its value until the next word is presented.

## Test plan
- Single packet, exact header: defaults with PKTS_PER_REQ=1; send 16 setup bits, A5, ch=01, len=3, words 11 22 33 -> three word_valid pulses with word_ch=1 and data 0x11, 0x22, 0x33; then pkt_done; then CS high; busy=0.
- Tolerant header: MATCH_MIN=7; send header 0xA4 (1-bit error) -> accepted. Send 0xA0 (2-bit error) followed by noise -> no accept.
- Timeout: send all-zero MISO -> after 4096 hunt bits, one pkt_err pulse, CS high, no word_valid, busy=0.
- Bad channel: ch=3 with NUM_CH=3 -> pkt_err, CS high, IDLE, no words.
- Two packets per request: ch0 len=2, then idle noise bits, then ch2 len=0 -> 2 words on ch0; pkt_done twice; CS held low between packets and high only after the second packet.
- Overflow and reset: hold word_ready=0 during a payload -> overflow=1 after the first word. Assert rst mid-payload -> CS=1, overflow=0, IDLE; the next request completes normally.
